// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one WIDTH-bit two's-complement add/sub datapath between two
// requesters. An arbiter picks one valid requester, its operands are captured,
// the add/sub runs for one cycle, and the registered result is held under a
// valid/ready handshake. The result is tagged with the port that issued it.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   r0_valid/r0_ready           port 0 request handshake
//   r0_a, r0_b, r0_op           port 0 operands and op (0 = A+B, 1 = A-B)
//   r1_*                        same as port 0, for port 1
//   res_valid/res_ready         result handshake
//   res_id                      port that issued the result
//   res_s                       sum/difference modulo 2^WIDTH
//   res_ovf                     signed overflow
//   res_lt                      signed A<B for subtract, 0 for add
module alu_share_arbiter #(
  parameter int WIDTH      = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_s,
  output logic             res_ovf,
  output logic             res_lt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    last_q, last_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic signed [WIDTH-1:0] b_q, b_d;
  logic                    op_q, op_d;
  logic                    id_q, id_d;
  logic                    res_valid_q, res_valid_d;
  logic                    res_id_q, res_id_d;
  logic signed [WIDTH-1:0] res_s_q, res_s_d;
  logic                    res_ovf_q, res_ovf_d;
  logic                    res_lt_q, res_lt_d;

  logic                    grant_id;
  logic                    accept;
  logic [WIDTH+1:0]        alu;

  // Returns {s, ovf, lt}. Subtraction is A + ~B + 1, so B = most-negative
  // value is handled by the carry-in. Overflow is carry-into-MSB XOR
  // carry-out-of-MSB; the carry into the MSB comes from summing the low bits.
  function automatic logic [WIDTH+1:0] addsub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic                    op
  );
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] low;
    logic [WIDTH:0]   full;
    logic             ovf;
    logic             lt;
    y    = b ^ {WIDTH{op}};
    low  = {1'b0, a[WIDTH-2:0]} + {1'b0, y[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, op};
    full = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, op};
    ovf  = low[WIDTH-1] ^ full[WIDTH];
    lt   = op & (full[WIDTH-1] ^ ovf);
    return {full[WIDTH-1:0], ovf, lt};
  endfunction

  // Arbitration: with a single valid port that port wins; under contention
  // round-robin picks the port that did not win last, fixed priority picks 0.
  always_comb begin
    grant_id = ~r0_valid;
    if (r0_valid && r1_valid) begin
      grant_id = FIXED_PRIO ? 1'b0 : ~last_q;
    end
  end

  // Readies are forced low while reset is asserted.
  assign r0_ready = rst_n & (state_q == ST_IDLE) & r0_valid & ~grant_id;
  assign r1_ready = rst_n & (state_q == ST_IDLE) & r1_valid &  grant_id;
  assign accept   = r0_ready | r1_ready;

  assign alu = addsub(a_q, b_q, op_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_s_d     = res_s_q;
    res_ovf_d   = res_ovf_q;
    res_lt_d    = res_lt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = grant_id ? r1_a  : r0_a;
          b_d     = grant_id ? r1_b  : r0_b;
          op_d    = grant_id ? r1_op : r0_op;
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_s_d     = alu[WIDTH+1:2];
        res_ovf_d   = alu[1];
        res_lt_d    = alu[0];
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture stage: control and visible result state, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_s_q     <= '0;
      res_ovf_q   <= 1'b0;
      res_lt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_s_q     <= res_s_d;
      res_ovf_q   <= res_ovf_d;
      res_lt_q    <= res_lt_d;
    end
  end

  // Operand stage: only read in EXEC after a capture, so no reset needed.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
    id_q <= id_d;
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_s     = res_s_q;
  assign res_ovf   = res_ovf_q;
  assign res_lt    = res_lt_q;

endmodule
